alu_flag_ir_unit: RTL and testbench

ALU_FLAG_IR_UNIT -- requirements
Module: alu_flag_ir_unit

---
 rtl/alu_flag_ir_unit.sv | 82 ++++++++
 tb/tb_alu_flag_ir_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/alu_flag_ir_unit.sv
// alu_flag_ir_unit: 32-bit combinational ALU with a registered NZCV flag register and instruction register.
// Define CARRY_FROM_FDR_EN to take the ALU carry-in from the stored C flag instead of cin.
module alu_flag_ir_unit #(
    parameter logic [31:0] IR_RST_VAL = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  op,
    input  logic        cin,
    input  logic        frld,
    input  logic        irld,
    input  logic [31:0] ir_in,
    output logic [31:0] result,
    output logic        flag_n,
    output logic        flag_z,
    output logic        flag_c,
    output logic        flag_v,
    output logic [3:0]  fdr_out,
    output logic [31:0] ir_out
);
    logic [3:0]  fdr_q, fdr_d;
    logic [31:0] ir_q, ir_d;
    logic        c, arith;
    logic [31:0] x, y, lr;
    logic [32:0] k, sum;
`ifdef CARRY_FROM_FDR_EN
    logic unused_cin;
    assign unused_cin = cin;
    assign c = fdr_q[1];
`else
    assign c = cin;
`endif
    // Every arithmetic op is x + y + k; subtraction uses ~operand + 1 so sum[32] is NOT borrow.
    always_comb begin
        x = a;
        y = b;
        k = 33'd0;
        arith = 1'b1;
        lr = 32'd0;
        case (op)
            5'd0, 5'd8:  begin arith = 1'b0; lr = a & b; end
            5'd1, 5'd9:  begin arith = 1'b0; lr = a ^ b; end
            5'd2, 5'd10: begin y = ~b; k = 33'd1; end
            5'd3:        begin x = b; y = ~a; k = 33'd1; end
            5'd4, 5'd11: arith = 1'b1;
            5'd5:        k = {32'd0, c};
            5'd6:        begin y = ~b; k = {32'd0, c}; end
            5'd7:        begin x = b; y = ~a; k = {32'd0, c}; end
            5'd12:       begin arith = 1'b0; lr = a | b; end
            5'd13:       begin arith = 1'b0; lr = b; end
            5'd14:       begin arith = 1'b0; lr = a & ~b; end
            5'd15:       begin arith = 1'b0; lr = ~b; end
            5'd16:       y = 32'd4;
            5'd17:       begin arith = 1'b0; lr = a; end
            5'd18:       begin arith = 1'b0; lr = b; end
            5'd19:       begin y = ~32'd4; k = 33'd1; end
            5'd20:       k = 33'd4;
            default:     arith = 1'b0;
        endcase
        sum = {1'b0, x} + {1'b0, y} + k;
        result = arith ? sum[31:0] : lr;
        flag_c = arith ? sum[32] : c;
        flag_v = arith & (x[31] == y[31]) & (sum[31] != x[31]);
    end
    assign flag_n = result[31];
    assign flag_z = (result == 32'd0);
    assign fdr_d = frld ? {flag_n, flag_z, flag_c, flag_v} : fdr_q;
    assign ir_d = irld ? ir_in : ir_q;
    always_ff @(posedge CLK) begin
        if (CLR) begin
            fdr_q <= 4'b0000;
            ir_q <= IR_RST_VAL;
        end else begin
            fdr_q <= fdr_d;
            ir_q <= ir_d;
        end
    end
    assign fdr_out = fdr_q;
    assign ir_out = ir_q;
endmodule

// File: tb/tb_alu_flag_ir_unit.sv
// tb_alu_flag_ir_unit: scoreboard bench for alu_flag_ir_unit; expected ALU outputs queued at drive time.
// Honours CARRY_FROM_FDR_EN the same way as the design.
module tb_alu_flag_ir_unit;
    localparam logic [31:0] RST = 32'hDEAD_BEEF;
    logic        CLK = 1'b0, CLR, cin, frld, irld;
    logic [31:0] a, b, ir_in, result, ir_out;
    logic [4:0]  op;
    logic        flag_n, flag_z, flag_c, flag_v;
    logic [3:0]  fdr_out, fdr_m;
    logic [31:0] ir_m;
    logic [35:0] exp_q[$];
    int          n_chk = 0, n_fail = 0;

    alu_flag_ir_unit #(.IR_RST_VAL(RST)) dut (
        .CLK(CLK), .CLR(CLR), .a(a), .b(b), .op(op), .cin(cin), .frld(frld), .irld(irld),
        .ir_in(ir_in), .result(result), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
        .flag_v(flag_v), .fdr_out(fdr_out), .ir_out(ir_out)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic, carry/overflow judged by range of the true result.
    function automatic logic [35:0] model(input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv, input logic cv);
        longint ua = longint'(av), ub = longint'(bv), sa = longint'($signed(av)), sb = longint'($signed(bv));
        longint cc = cv ? 1 : 0, ur = 0, sr = 0;
        logic [31:0] r;
        logic ar = 1'b1, sub = 1'b0, fc, fv;
        r = 32'd0;
        case (o)
            0, 8:   begin ar = 1'b0; r = av & bv; end
            1, 9:   begin ar = 1'b0; r = av ^ bv; end
            2, 10:  begin ur = ua - ub; sr = sa - sb; sub = 1'b1; end
            3:      begin ur = ub - ua; sr = sb - sa; sub = 1'b1; end
            4, 11:  begin ur = ua + ub; sr = sa + sb; end
            5:      begin ur = ua + ub + cc; sr = sa + sb + cc; end
            6:      begin ur = ua - ub - (1 - cc); sr = sa - sb - (1 - cc); sub = 1'b1; end
            7:      begin ur = ub - ua - (1 - cc); sr = sb - sa - (1 - cc); sub = 1'b1; end
            12:     begin ar = 1'b0; r = av | bv; end
            13, 18: begin ar = 1'b0; r = bv; end
            14:     begin ar = 1'b0; r = av & ~bv; end
            15:     begin ar = 1'b0; r = ~bv; end
            16:     begin ur = ua + 4; sr = sa + 4; end
            17:     begin ar = 1'b0; r = av; end
            19:     begin ur = ua - 4; sr = sa - 4; sub = 1'b1; end
            20:     begin ur = ua + ub + 4; sr = sa + sb + 4; end
            default: ar = 1'b0;
        endcase
        if (ar) r = ur[31:0];
        fc = ar ? (sub ? (ur >= 0) : (ur > 64'sh0FFFF_FFFF)) : cv;
        fv = ar && (sr > 64'sh7FFF_FFFF || sr < -64'sh8000_0000);
        return {r, r[31], r == 32'd0, fc, fv};
    endfunction

    task automatic step(input string tag, input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input logic fl, input logic il, input logic [31:0] iv, input logic cl);
        logic [35:0] e;
        logic ce;
        op = o; a = av; b = bv; cin = ci; frld = fl; irld = il; ir_in = iv; CLR = cl;
`ifdef CARRY_FROM_FDR_EN
        ce = fdr_m[1];
`else
        ce = ci;
`endif
        e = model(o, av, bv, ce);
        exp_q.push_back(e);
        #1;
        if (exp_q.size() == 0) chk({tag, "_sb"}, 64'd0, 64'd1);
        else chk({tag, "_alu"}, {result, flag_n, flag_z, flag_c, flag_v}, exp_q.pop_front());
        @(posedge CLK);
        if (cl) begin
            fdr_m = 4'b0000;
            ir_m = RST;
        end else begin
            if (fl) fdr_m = e[3:0];
            if (il) ir_m = iv;
        end
        #1;
        chk({tag, "_fdr"}, fdr_out, fdr_m);
        chk({tag, "_ir"}, ir_out, ir_m);
        @(negedge CLK);
    endtask

    initial begin
        CLR = 1'b1; frld = 1'b1; irld = 1'b1; ir_in = 32'h1234_5678;
        a = 32'd0; b = 32'd0; op = 5'd0; cin = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst_fdr", fdr_out, 4'b0000);
        chk("rst_ir", ir_out, RST);
        fdr_m = 4'b0000;
        ir_m = RST;
        @(negedge CLK);
        step("add_ovf", 5'd4, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("add_ovf_const", {result, fdr_out}, {32'h8000_0000, 4'b1001});
        step("cmp_eq", 5'd10, 32'd5, 32'd5, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("cmp_eq_fdr_const", fdr_out, 4'b0110);
        step("cmp_lt", 5'd10, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("adc", 5'd5, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("adc_fdr_const", fdr_out, 4'b0110);
        step("adc_c0", 5'd5, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("ir_ld", 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hE3A0_1005, 1'b0);
        chk("ir_ld_const", ir_out, 32'hE3A0_1005);
        step("ir_hold", 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0);
        step("op16", 5'd16, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("op25", 5'd25, 32'h55, 32'hAA, 1'b1, 1'b1, 1'b1, 32'h0000_0025, 1'b0);
        step("wrap", 5'd4, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step("sub_bor", 5'd2, 32'h0, 32'h1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step("sub_ovf", 5'd2, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step("rsb", 5'd3, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step("a_m4", 5'd19, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step("both_ld", 5'd11, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 32'hCAFE_0001, 1'b0);
        step("clr_mid", 5'd4, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b1, 1'b1, 32'h1111_2222, 1'b1);
        for (int r = 0; r < 3; r++) begin
            for (int o = 0; o < 32; o++) begin
                logic [31:0] av, bv;
                av = $urandom;
                bv = ($urandom_range(0, 7) == 0) ? av : $urandom;
                if (o == 20) begin
                    av &= 32'h0FFF_FFFF;
                    bv &= 32'h0FFF_FFFF;
                end
                step("rnd", o[4:0], av, bv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 15) == 0));
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
